// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: job FIFO feeding controller_fsm one job at a time; CONV_JOB_SCHED_CYCLE_COUNT_EN adds a saturating job cycle counter.
// Latency: push->ctrl_start 2 cycles; backpressure: job_ready = !full, completion record held until done_ready.
module conv_job_scheduler #(
  parameter int QUEUE_DEPTH      = 4,
  parameter int LOG2_QUEUE_DEPTH = 2,
  parameter int ID_WIDTH         = 8,
  parameter int CFG_WIDTH        = 32,
  parameter int START_TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [ID_WIDTH-1:0]         job_id,
  input  logic [CFG_WIDTH-1:0]        job_cfg,
  output logic                        ctrl_start,
  input  logic                        ctrl_running,
  output logic [CFG_WIDTH-1:0]        ctrl_cfg,
  output logic                        done_valid,
  input  logic                        done_ready,
  output logic [ID_WIDTH-1:0]         done_id,
  output logic                        done_err,
  output logic [31:0]                 done_cycles,
  output logic                        busy,
  output logic [LOG2_QUEUE_DEPTH:0]   queue_level
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT_RUN = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_REPORT   = 3'd4;

  localparam int TW = $clog2(START_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [LOG2_QUEUE_DEPTH:0] LEVEL_FULL = (LOG2_QUEUE_DEPTH + 1)'(QUEUE_DEPTH);

  logic [2:0]                        state;
  logic [ID_WIDTH+CFG_WIDTH-1:0]     mem [QUEUE_DEPTH];
  logic [LOG2_QUEUE_DEPTH-1:0]       wr_ptr;
  logic [LOG2_QUEUE_DEPTH-1:0]       rd_ptr;
  logic [LOG2_QUEUE_DEPTH:0]         level;
  logic [TW-1:0]                     tmo_cnt;
  logic                              push;
  logic                              pop;
  logic [ID_WIDTH-1:0]               head_id;
  logic [CFG_WIDTH-1:0]              head_cfg;

  assign job_ready   = (level != LEVEL_FULL);
  assign push        = job_valid && job_ready;
  assign pop         = (state == S_IDLE) && (level != '0);
  assign {head_id, head_cfg} = mem[rd_ptr];

  assign ctrl_start  = (state == S_LAUNCH);
  assign done_valid  = (state == S_REPORT);
  assign busy        = (state != S_IDLE);
  assign queue_level = level;

  // Storage is not reset; the pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {job_id, job_cfg};
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state    <= S_IDLE;
      ctrl_cfg <= '0;
      done_id  <= '0;
      done_err <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            ctrl_cfg <= head_cfg;
            done_id  <= head_id;
            done_err <= 1'b0;
            tmo_cnt  <= '0;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT_RUN;
        S_WAIT_RUN: begin
          if (ctrl_running) begin
            state <= S_RUN;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            done_err <= 1'b1;
            state    <= S_REPORT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!ctrl_running) state <= S_REPORT;
        end
        S_REPORT: begin
          if (done_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_JOB_SCHED_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      cyc_cnt <= '0;
    end else if (pop) begin
      cyc_cnt <= '0;
    end else if (((state == S_LAUNCH) || (state == S_WAIT_RUN) || (state == S_RUN)) &&
                 (cyc_cnt != 32'hFFFF_FFFF)) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign done_cycles = cyc_cnt;
`else
  assign done_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler: drives host and controller by hand, checks against hand-computed values.
module tb_conv_job_scheduler;

  logic        clk;
  logic        arst_n_in;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_id;
  logic [31:0] job_cfg;
  logic        ctrl_start;
  logic        ctrl_running;
  logic [31:0] ctrl_cfg;
  logic        done_valid;
  logic        done_ready;
  logic [7:0]  done_id;
  logic        done_err;
  logic [31:0] done_cycles;
  logic        busy;
  logic [2:0]  queue_level;

  int checks;
  int failures;

`ifdef CONV_JOB_SCHED_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  conv_job_scheduler #(
    .QUEUE_DEPTH(4), .LOG2_QUEUE_DEPTH(2), .ID_WIDTH(8), .CFG_WIDTH(32), .START_TIMEOUT(16)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id), .job_cfg(job_cfg),
    .ctrl_start(ctrl_start), .ctrl_running(ctrl_running), .ctrl_cfg(ctrl_cfg),
    .done_valid(done_valid), .done_ready(done_ready), .done_id(done_id),
    .done_err(done_err), .done_cycles(done_cycles),
    .busy(busy), .queue_level(queue_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cfg_of(input logic [7:0] id);
    return 32'hA500_0000 | {24'h0, id};
  endfunction

  function automatic logic [31:0] exp_cyc(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller stand-in: waits for start, raises running from the next cycle for run_len cycles, waits for the record.
  task automatic serve(input int run_len, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (ctrl_start !== 1'b1 && n < 40) begin tick(); n++; end
    if (ctrl_start !== 1'b1) return;
    tick();
    ctrl_running = 1'b1;
    repeat (run_len) tick();
    ctrl_running = 1'b0;
    n = 0;
    while (done_valid !== 1'b1 && n < 10) begin tick(); n++; end
    ok = (done_valid === 1'b1);
  endtask

  task automatic accept();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, queue_level, done_valid, ctrl_start, done_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%b lvl=%0d dv=%b st=%b err=%b expected all 0",
               busy, queue_level, done_valid, ctrl_start, done_err);
    end
    checks++;
    if ({ctrl_cfg, done_id, done_cycles} !== 72'h0) begin
      failures++;
      $display("FAIL reset_data: got cfg=%h id=%h cyc=%h expected 0", ctrl_cfg, done_id, done_cycles);
    end
    arst_n_in = 1'b1;
    tick();
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", job_ready, busy);
    end
  endtask

  task automatic test_single_job();
    int starts;
    int early;
    job_valid = 1'b1; job_id = 8'h05; job_cfg = 32'hDEAD_BEEF;
    tick();
    job_valid = 1'b0;
    checks++;
    if (queue_level !== 3'd1 || busy !== 1'b0 || ctrl_start !== 1'b0) begin
      failures++;
      $display("FAIL single_push: got lvl=%0d busy=%b st=%b expected 1 0 0", queue_level, busy, ctrl_start);
    end
    tick();
    checks++;
    if (ctrl_start !== 1'b1 || ctrl_cfg !== 32'hDEAD_BEEF || queue_level !== 3'd0) begin
      failures++;
      $display("FAIL single_launch: got st=%b cfg=%h lvl=%0d expected 1 deadbeef 0", ctrl_start, ctrl_cfg, queue_level);
    end
    starts = 1;
    early = 0;
    tick();
    if (ctrl_start === 1'b1) starts++;
    ctrl_running = 1'b1;
    repeat (10) begin
      tick();
      if (ctrl_start === 1'b1) starts++;
      if (done_valid === 1'b1) early++;
    end
    ctrl_running = 1'b0;
    tick();
    checks++;
    if (done_valid !== 1'b1 || done_id !== 8'h05 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got dv=%b id=%h err=%b expected 1 05 0", done_valid, done_id, done_err);
    end
    checks++;
    if (done_cycles !== exp_cyc(12)) begin
      failures++;
      $display("FAIL single_cycles: got %0d expected %0d", done_cycles, exp_cyc(12));
    end
    checks++;
    if (starts != 1 || early != 0) begin
      failures++;
      $display("FAIL single_pulses: got starts=%0d early_done=%0d expected 1 0", starts, early);
    end
    accept();
    checks++;
    if (done_valid !== 1'b0 || busy !== 1'b0 || ctrl_cfg !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_idle: got dv=%b busy=%b cfg=%h expected 0 0 deadbeef", done_valid, busy, ctrl_cfg);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    ctrl_running = 1'b1;
    job_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      job_id = 8'h10 + 8'(i);
      job_cfg = cfg_of(job_id);
      checks++;
      if (job_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d: got %b expected 1", i, job_ready);
      end
      tick();
    end
    job_id = 8'h15; job_cfg = cfg_of(8'h15);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (queue_level !== 3'd4 || job_ready !== 1'b0 || ctrl_start !== 1'b0) begin
        failures++;
        $display("FAIL b2b_full_%0d: got lvl=%0d ready=%b st=%b expected 4 0 0", i, queue_level, job_ready, ctrl_start);
      end
      tick();
    end
    ctrl_running = 1'b0;
    tick();
    checks++;
    if (done_valid !== 1'b1 || done_id !== 8'h10) begin
      failures++;
      $display("FAIL b2b_done0: got dv=%b id=%h expected 1 10", done_valid, done_id);
    end
    accept();
    checks++;
    if (queue_level !== 3'd4 || job_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got lvl=%0d ready=%b busy=%b expected 4 0 0", queue_level, job_ready, busy);
    end
    tick();
    checks++;
    if (queue_level !== 3'd3 || job_ready !== 1'b1 || ctrl_start !== 1'b1 || ctrl_cfg !== cfg_of(8'h11)) begin
      failures++;
      $display("FAIL b2b_pop_full: got lvl=%0d ready=%b st=%b cfg=%h expected 3 1 1 %h",
               queue_level, job_ready, ctrl_start, ctrl_cfg, cfg_of(8'h11));
    end
    tick();
    job_valid = 1'b0;
    checks++;
    if (queue_level !== 3'd4) begin
      failures++;
      $display("FAIL b2b_late_push: got lvl=%0d expected 4", queue_level);
    end
    ctrl_running = 1'b1;
    tick();
    tick();
    ctrl_running = 1'b0;
    n = 0;
    while (done_valid !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (done_valid !== 1'b1 || done_id !== 8'h11 || done_cycles !== exp_cyc(4)) begin
      failures++;
      $display("FAIL b2b_done1: got dv=%b id=%h cyc=%0d expected 1 11 %0d", done_valid, done_id, done_cycles, exp_cyc(4));
    end
    accept();
    for (int i = 2; i < 6; i++) begin
      serve(3, ok);
      checks++;
      if (!ok || done_id !== 8'h10 + 8'(i) || done_err !== 1'b0 || done_cycles !== exp_cyc(5)) begin
        failures++;
        $display("FAIL b2b_order_%0d: got ok=%b id=%h err=%b cyc=%0d expected 1 %h 0 %0d",
                 i, ok, done_id, done_err, done_cycles, 8'h10 + 8'(i), exp_cyc(5));
      end
      accept();
    end
    checks++;
    if (queue_level !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got lvl=%0d busy=%b expected 0 0", queue_level, busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    ctrl_running = 1'b0;
    job_valid = 1'b1; job_id = 8'h20; job_cfg = cfg_of(8'h20);
    tick();
    job_id = 8'h21; job_cfg = cfg_of(8'h21);
    tick();
    job_valid = 1'b0;
    checks++;
    if (queue_level !== 3'd1 || ctrl_start !== 1'b1) begin
      failures++;
      $display("FAIL tmo_push_pop: got lvl=%0d st=%b expected 1 1", queue_level, ctrl_start);
    end
    n = 0;
    while (done_valid !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 17) begin
      failures++;
      $display("FAIL tmo_latency: got %0d cycles from launch to record expected 17", n);
    end
    checks++;
    if (done_valid !== 1'b1 || done_err !== 1'b1 || done_id !== 8'h20 || done_cycles !== exp_cyc(17)) begin
      failures++;
      $display("FAIL tmo_record: got dv=%b err=%b id=%h cyc=%0d expected 1 1 20 %0d",
               done_valid, done_err, done_id, done_cycles, exp_cyc(17));
    end
    accept();
    serve(4, ok);
    checks++;
    if (!ok || done_id !== 8'h21 || done_err !== 1'b0 || done_cycles !== exp_cyc(6)) begin
      failures++;
      $display("FAIL tmo_next_job: got ok=%b id=%h err=%b cyc=%0d expected 1 21 0 %0d",
               ok, done_id, done_err, done_cycles, exp_cyc(6));
    end
    accept();
  endtask

  task automatic test_done_hold();
    bit ok;
    job_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      job_id = 8'h30 + 8'(i);
      job_cfg = cfg_of(job_id);
      tick();
    end
    job_valid = 1'b0;
    ctrl_running = 1'b1;
    tick();
    ctrl_running = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({done_valid, done_id, done_err, ctrl_start, queue_level} !== {1'b1, 8'h30, 1'b0, 1'b0, 3'd2} ||
          done_cycles !== exp_cyc(3)) begin
        failures++;
        $display("FAIL hold_%0d: got dv=%b id=%h err=%b st=%b lvl=%0d cyc=%0d expected 1 30 0 0 2 %0d",
                 i, done_valid, done_id, done_err, ctrl_start, queue_level, done_cycles, exp_cyc(3));
      end
      tick();
    end
    accept();
    checks++;
    if (done_valid !== 1'b0 || ctrl_start !== 1'b0) begin
      failures++;
      $display("FAIL hold_after_accept: got dv=%b st=%b expected 0 0", done_valid, ctrl_start);
    end
    tick();
    checks++;
    if (ctrl_start !== 1'b1 || ctrl_cfg !== cfg_of(8'h31) || queue_level !== 3'd1) begin
      failures++;
      $display("FAIL hold_relaunch: got st=%b cfg=%h lvl=%0d expected 1 %h 1", ctrl_start, ctrl_cfg, queue_level, cfg_of(8'h31));
    end
    for (int i = 1; i < 3; i++) begin
      serve(2, ok);
      checks++;
      if (!ok || done_id !== 8'h30 + 8'(i) || done_cycles !== exp_cyc(4)) begin
        failures++;
        $display("FAIL hold_tail_%0d: got ok=%b id=%h cyc=%0d expected 1 %h %0d",
                 i, ok, done_id, done_cycles, 8'h30 + 8'(i), exp_cyc(4));
      end
      accept();
    end
  endtask

  task automatic test_reset_mid_job();
    int dv_seen;
    int st_seen;
    job_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      job_id = 8'h40 + 8'(i);
      job_cfg = cfg_of(job_id);
      tick();
    end
    job_valid = 1'b0;
    ctrl_running = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || queue_level !== 3'd2) begin
      failures++;
      $display("FAIL rst_pre: got busy=%b lvl=%0d expected 1 2", busy, queue_level);
    end
    arst_n_in = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || queue_level !== 3'd0 || done_valid !== 1'b0 || ctrl_start !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got busy=%b lvl=%0d dv=%b st=%b expected 0 0 0 0", busy, queue_level, done_valid, ctrl_start);
    end
    tick();
    arst_n_in = 1'b1;
    ctrl_running = 1'b0;
    dv_seen = 0;
    st_seen = 0;
    repeat (20) begin
      tick();
      if (done_valid === 1'b1) dv_seen++;
      if (ctrl_start === 1'b1) st_seen++;
    end
    checks++;
    if (dv_seen != 0 || st_seen != 0 || queue_level !== 3'd0 || job_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_stale: got dv_cycles=%0d start_cycles=%0d lvl=%0d ready=%b expected 0 0 0 1",
               dv_seen, st_seen, queue_level, job_ready);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    arst_n_in = 1'b0;
    job_valid = 1'b0;
    job_id = '0;
    job_cfg = '0;
    ctrl_running = 1'b0;
    done_ready = 1'b0;
    test_reset();
    test_single_job();
    test_back_to_back();
    test_timeout();
    test_done_hold();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_job_scheduler.md
# conv_job_scheduler

Queues convolution job descriptors from the host and sequences them one at a time into `controller_fsm` through its `start`/`running` handshake. It sits between the host command interface and the convolution controller. For each job it latches a configuration word, launches the controller and waits for completion. It then returns a completion record carrying the job id, an error flag and an optional cycle count.

## Interface
- `QUEUE_DEPTH`, 4: job FIFO entries; must be a power of two, ≥2.
- `LOG2_QUEUE_DEPTH`, 2: log2(`QUEUE_DEPTH`).
- `ID_WIDTH`, 8: job id width.
- `CFG_WIDTH`, 32: job configuration word width.
- `START_TIMEOUT`, 16: cycles allowed in WAIT_RUN before the job is reported as failed; ≥2.
- `clk`  in  1  clock.
- `arst_n_in`  in  1  asynchronous reset, active low.
- `job_valid`  in  1  host job descriptor valid.
- `job_ready`  out  1  FIFO can accept a job (= !full).
- `job_id`  in  `ID_WIDTH`  job identifier.
- `job_cfg`  in  `CFG_WIDTH`  configuration word forwarded to the controller/datapath.
- `ctrl_start`  out  1  one-cycle launch pulse to the controller's `start`.
- `ctrl_running`  in  1  controller's `running`.
- `ctrl_cfg`  out  `CFG_WIDTH`  configuration of the current or most recent job.
- `done_valid`  out  1  completion record valid.
- `done_ready`  in  1  host accepts the completion record.
- `done_id`  out  `ID_WIDTH`  id of the completed job.
- `done_err`  out  1  1 = start timeout; the controller never reported running.
- `done_cycles`  out  32  job duration in cycles.
- `busy`  out  1  state != IDLE.
- `queue_level`  out  `LOG2_QUEUE_DEPTH`+1  FIFO occupancy.

## Operation
- FIFO (circular buffer, wrapping read/write pointers plus an occupancy counter):
  - Push on `job_valid && job_ready`; pop only in IDLE when `queue_level != 0`.
  - Push and pop in the same cycle: `queue_level` is unchanged.
  - `job_ready` depends only on the registered level. When full, no push is accepted even in a pop cycle.
- FSM states: IDLE, LAUNCH, WAIT_RUN, RUN, REPORT.
  - IDLE: if the FIFO is non-empty, pop the head, latch `ctrl_cfg` and the current id, clear the counters, go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: `ctrl_start`=1 (only in this state); go to WAIT_RUN.
  - WAIT_RUN:
    - If `ctrl_running`=1, go to RUN.
    - Otherwise increment the timeout counter. When it reaches `START_TIMEOUT`-1 with `ctrl_running` still 0, set the error flag and go to REPORT.
  - RUN: go to REPORT when `ctrl_running`=0; otherwise stay.
  - REPORT: `done_valid`=1; `done_id`/`done_err`/`done_cycles` are held stable. On `done_ready`, go to IDLE.
- `ctrl_cfg` holds its value from the pop until the next pop.
- `ctrl_running` is ignored in IDLE and REPORT.
- Cycle counter (see Configuration): cleared at pop. Increments in every LAUNCH, WAIT_RUN and RUN cycle. Saturates at 0xFFFF_FFFF.
- Reset: state IDLE, FIFO empty, all outputs 0 (`job_ready`=1 once out of reset). Reset mid-job discards the queued and in-flight jobs; no completion record is produced for them.

## Timing
- A job pushed into an empty FIFO in IDLE at edge N:
  - N+1: level 1, state IDLE.
  - Edge N+1: pop, LAUNCH.
  - `ctrl_start` is high for exactly the cycle after edge N+1.
- A controller that raises `running` one cycle after `start` is seen in the first WAIT_RUN cycle.
- Completion:
  - `done_valid` rises one cycle after the first `ctrl_running`=0 cycle in RUN.
  - The next job's `ctrl_start` comes no sooner than 2 cycles after the `done_ready` handshake (REPORT→IDLE→LAUNCH).
- Minimum gap between successive `ctrl_start` pulses: 5 cycles.
- `done_cycles` equals the number of LAUNCH+WAIT_RUN+RUN cycles for the job.

## Configuration
- `CONV_JOB_SCHED_CYCLE_COUNT_EN` defined: the 32-bit saturating cycle counter is compiled in and drives `done_cycles`.
- Not defined: no counter register; `done_cycles` is tied to 0. All other behaviour is identical.

## Test plan
- Single job, id 0x05, cfg 0xDEADBEEF; `running` high for 10 cycles starting 1 cycle after `start`:
  - one `ctrl_start` pulse; `ctrl_cfg`=0xDEADBEEF.
  - `done_id`=0x05, `done_err`=0, `done_cycles`=12 (with macro).
- Push 5 jobs back-to-back while the controller is held running:
  - `job_ready`=0 once the level reaches 4 (first job popped, 4 queued).
  - The 5th job is accepted after the next pop; completions arrive in id order.
- `ctrl_running` tied 0 → `done_valid` with `done_err`=1 after 16 WAIT_RUN cycles; the next job launches normally.
- `done_ready` held 0 for 7 cycles in REPORT → record stable, no new `ctrl_start` while the FIFO holds 2 jobs; launch 2 cycles after acceptance.
- Push and pop in the same cycle at level 1 → `queue_level` stays 1; pointers wrap correctly after 8 total jobs.
- Assert `arst_n_in` in RUN with 2 jobs queued → `busy`=0, `queue_level`=0, `done_valid`=0, `ctrl_start`=0 immediately; no stale completion after release.
